// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, ALU operation encodings,
// instruction classes and the control bundle carried into ID/EX.
package id_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_OP_MEM    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_R      = 2'b10;
    localparam logic [1:0] ALU_OP_I      = 2'b11;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } instr_class_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return CLS_R;
            OP_I:      return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            default:   return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic ctrl_t ctrl_of(input instr_class_e cls);
        ctrl_t c;
        c = CTRL_NOP;
        case (cls)
            CLS_R:      begin c.alu_op = ALU_OP_R; c.reg_write = 1'b1; end
            CLS_I:      begin c.alu_op = ALU_OP_I; c.alu_src = 1'b1; c.reg_write = 1'b1; end
            CLS_LOAD:   begin
                c.alu_op     = ALU_OP_MEM;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            CLS_STORE:  begin c.alu_op = ALU_OP_MEM; c.alu_src = 1'b1; c.mem_write = 1'b1; end
            CLS_BRANCH: begin c.alu_op = ALU_OP_BRANCH; c.branch = 1'b1; end
            default:    c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file with x0 hardwired to zero and write-through,
// so an instruction decoded in the write-back cycle sees the new value.
module regfile_bypass #(
    parameter int XLEN = 8,
    parameter int NREG = 32,
    localparam int RW = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [RW-1:0]   rd_addr_a,
    output logic [XLEN-1:0] rd_data_a,
    input  logic [RW-1:0]   rd_addr_b,
    output logic [XLEN-1:0] rd_data_b,
    input  logic            wr_en,
    input  logic [RW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (rd_addr_a == '0)
            rd_data_a = '0;
        else if (wr_en && wr_addr == rd_addr_a)
            rd_data_a = wr_data;
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_b == '0)
            rd_data_b = '0;
        else if (wr_en && wr_addr == rd_addr_b)
            rd_data_b = wr_data;
    end

endmodule

// File: rtl/id_stage_hazard.sv
// Instruction-decode stage: decode, immediate generation, bypassed register read,
// load-use stall detection, flush-to-bubble and saturating stall/flush counters.
module id_stage_hazard
    import id_pkg::*;
#(
    parameter int PC_SIZE = 10,
    parameter int XLEN    = 8,
    parameter int NREG    = 32,
    parameter int CNT_W   = 16,
    localparam int RW     = $clog2(NREG)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               if_valid,
    input  logic [PC_SIZE-1:0] pc_in,
    input  logic [31:0]        instr_in,
    input  logic               flush,
    input  logic               wb_we,
    input  logic [RW-1:0]      wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               stall,
    output logic               ex_valid,
    output logic [PC_SIZE-1:0] ex_pc,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [RW-1:0]      ex_rs1,
    output logic [RW-1:0]      ex_rs2,
    output logic [RW-1:0]      ex_rd,
    output logic [11:0]        ex_imm,
    output logic [9:0]         ex_funct,
    output logic [1:0]         ex_alu_op,
    output logic               ex_alu_src,
    output logic               ex_branch,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_reg_write,
    output logic               ex_illegal,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic [RW-1:0]   rs1, rs2, rd;
    logic [XLEN-1:0] rs1_data, rs2_data;
    instr_class_e    cls;
    ctrl_t           ctrl, ex_ctrl;
    logic [11:0]     imm;
    logic            illegal, use_rs1, use_rs2, load_use, issue;

    assign rs1 = instr_in[15 +: RW];
    assign rs2 = instr_in[20 +: RW];
    assign rd  = instr_in[7 +: RW];

    assign cls     = classify(instr_in[6:0]);
    assign ctrl    = ctrl_of(cls);
    assign illegal = (cls == CLS_ILLEGAL);
    assign use_rs1 = !illegal;
    assign use_rs2 = (cls == CLS_R) || (cls == CLS_STORE) || (cls == CLS_BRANCH);

    always_comb begin
        imm = '0;
        case (cls)
            CLS_I, CLS_LOAD: imm = instr_in[31:20];
            CLS_STORE:       imm = {instr_in[31:25], instr_in[11:7]};
            CLS_BRANCH:      imm = {instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8]};
            default:         imm = '0;
        endcase
    end

    regfile_bypass #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .rd_addr_a (rs1),
        .rd_data_a (rs1_data),
        .rd_addr_b (rs2),
        .rd_data_b (rs2_data),
        .wr_en     (wb_we),
        .wr_addr   (wb_rd),
        .wr_data   (wb_data)
    );

    // if_valid qualifies instr_in/pc_in; stall is the back-pressure: while it is 1
    // IF/ID holds and re-presents the same instruction. flush outranks stall.
    assign load_use = ex_valid && ex_ctrl.mem_read && (ex_rd != '0) &&
                      (((ex_rd == rs1) && use_rs1) || ((ex_rd == rs2) && use_rs2));
    assign stall    = if_valid && !flush && load_use;
    assign issue    = if_valid && !flush && !load_use;

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= CTRL_NOP;
            ex_illegal  <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_imm      <= '0;
            ex_funct    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (issue) begin
                ex_valid    <= 1'b1;
                ex_ctrl     <= ctrl;
                ex_illegal  <= illegal;
                ex_pc       <= pc_in;
                ex_rs1_data <= rs1_data;
                ex_rs2_data <= rs2_data;
                ex_rs1      <= rs1;
                ex_rs2      <= rs2;
                ex_rd       <= rd;
                ex_imm      <= imm;
                ex_funct    <= {instr_in[31:25], instr_in[14:12]};
            end else begin
                ex_valid    <= 1'b0;
                ex_ctrl     <= CTRL_NOP;
                ex_illegal  <= 1'b0;
                ex_pc       <= '0;
                ex_rs1_data <= '0;
                ex_rs2_data <= '0;
                ex_rs1      <= '0;
                ex_rs2      <= '0;
                ex_rd       <= '0;
                ex_imm      <= '0;
                ex_funct    <= '0;
            end
            if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush && if_valid && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign ex_alu_op     = ex_ctrl.alu_op;
    assign ex_alu_src    = ex_ctrl.alu_src;
    assign ex_branch     = ex_ctrl.branch;
    assign ex_mem_read   = ex_ctrl.mem_read;
    assign ex_mem_write  = ex_ctrl.mem_write;
    assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
    assign ex_reg_write  = ex_ctrl.reg_write;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Directed bench for id_stage_hazard: decode classes, bypass, load-use stall,
// flush priority, x0/illegal handling, counter saturation and mid-stream reset.
module tb_id_stage_hazard;

    localparam int PC_SIZE = 10;
    localparam int XLEN    = 8;
    localparam int NREG    = 32;
    localparam int CNT_W   = 4;
    localparam int RW      = 5;

    localparam logic [7:0] C_NONE = 8'b00000000;
    localparam logic [7:0] C_R    = 8'b10000001;
    localparam logic [7:0] C_I    = 8'b11100001;
    localparam logic [7:0] C_LOAD = 8'b00101011;
    localparam logic [7:0] C_ST   = 8'b00100100;
    localparam logic [7:0] C_BR   = 8'b01010000;

    logic               clock = 1'b0;
    logic               reset;
    logic               if_valid;
    logic [PC_SIZE-1:0] pc_in;
    logic [31:0]        instr_in;
    logic               flush;
    logic               wb_we;
    logic [RW-1:0]      wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               stall;
    logic               ex_valid;
    logic [PC_SIZE-1:0] ex_pc;
    logic [XLEN-1:0]    ex_rs1_data, ex_rs2_data;
    logic [RW-1:0]      ex_rs1, ex_rs2, ex_rd;
    logic [11:0]        ex_imm;
    logic [9:0]         ex_funct;
    logic [1:0]         ex_alu_op;
    logic               ex_alu_src, ex_branch, ex_mem_read, ex_mem_write;
    logic               ex_mem_to_reg, ex_reg_write, ex_illegal;
    logic [CNT_W-1:0]   stall_cnt, flush_cnt;
    logic [7:0]         ctrl_obs;

    int vectors = 0;
    int miscompares = 0;
    logic [RW-1:0] exp_q[$];

    id_stage_hazard #(.PC_SIZE(PC_SIZE), .XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .if_valid(if_valid), .pc_in(pc_in),
        .instr_in(instr_in), .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_funct(ex_funct),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_reg_write(ex_reg_write),
        .ex_illegal(ex_illegal), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctrl_obs = {ex_alu_op, ex_alu_src, ex_branch, ex_mem_read,
                       ex_mem_write, ex_mem_to_reg, ex_reg_write};

    // clock / reset
    always #5 clock = ~clock;

    // instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_addi(input logic [11:0] imm, input logic [4:0] rs1,
                                             input logic [4:0] rd);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_lw(input logic [4:0] rs1, input logic [4:0] rd);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction
    function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    // driver tasks
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic drive(input logic v, input logic [31:0] ins, input logic [PC_SIZE-1:0] pc);
        if_valid = v;
        instr_in = ins;
        pc_in    = pc;
    endtask
    task automatic wb(input logic we, input logic [RW-1:0] rd, input logic [XLEN-1:0] d);
        wb_we   = we;
        wb_rd   = rd;
        wb_data = d;
    endtask

    task automatic test_reset;
        reset = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, '0);
        wb(1'b0, '0, '0);
        tick; tick;
        vectors++; if (ex_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", ex_valid); end
        vectors++; if (ctrl_obs !== C_NONE) begin miscompares++; $display("FAIL reset_ctrl: got %b want %b", ctrl_obs, C_NONE); end
        vectors++; if ({ex_rd, ex_pc, ex_imm} !== '0) begin miscompares++; $display("FAIL reset_fields: rd %h pc %h imm %h want 0", ex_rd, ex_pc, ex_imm); end
        vectors++; if ({stall_cnt, flush_cnt, stall} !== '0) begin miscompares++; $display("FAIL reset_cnt: stall_cnt %0d flush_cnt %0d stall %b want 0", stall_cnt, flush_cnt, stall); end
        reset = 1'b0;
    endtask

    task automatic test_alu_bypass;
        wb(1'b1, 5'd3, 8'hA5); tick;
        wb(1'b1, 5'd2, 8'h11); tick;
        wb(1'b0, '0, '0);
        drive(1'b1, enc_r(7'h00, 5'd0, 5'd3, 5'd5), 10'h004); tick;
        vectors++; if (ex_valid !== 1'b1) begin miscompares++; $display("FAIL add_valid: got %b want 1", ex_valid); end
        vectors++; if (ctrl_obs !== C_R) begin miscompares++; $display("FAIL add_ctrl: got %b want %b", ctrl_obs, C_R); end
        vectors++; if ({ex_rd, ex_rs1_data, ex_rs2_data, ex_pc} !== {5'd5, 8'hA5, 8'h00, 10'h004}) begin miscompares++; $display("FAIL add_data: rd %0d rs1d %h rs2d %h pc %h want 5 a5 00 004", ex_rd, ex_rs1_data, ex_rs2_data, ex_pc); end
        drive(1'b1, enc_r(7'b0100000, 5'd2, 5'd3, 5'd9), 10'h008); tick;
        vectors++; if ({ex_funct, ex_rs1, ex_rs2, ex_rs2_data} !== {10'h100, 5'd3, 5'd2, 8'h11}) begin miscompares++; $display("FAIL sub_fields: funct %h rs1 %0d rs2 %0d rs2d %h want 100 3 2 11", ex_funct, ex_rs1, ex_rs2, ex_rs2_data); end
        wb(1'b1, 5'd7, 8'h3C);
        drive(1'b1, enc_addi(12'h004, 5'd7, 5'd1), 10'h00C); tick;
        wb(1'b0, '0, '0);
        vectors++; if ({ex_rs1_data, ex_imm, ex_rd} !== {8'h3C, 12'h004, 5'd1}) begin miscompares++; $display("FAIL addi_bypass: rs1d %h imm %h rd %0d want 3c 004 1", ex_rs1_data, ex_imm, ex_rd); end
        vectors++; if (ctrl_obs !== C_I) begin miscompares++; $display("FAIL addi_ctrl: got %b want %b", ctrl_obs, C_I); end
        tick;
        vectors++; if (ex_rs1_data !== 8'h3C) begin miscompares++; $display("FAIL addi_stored: rs1d %h want 3c", ex_rs1_data); end
    endtask

    task automatic test_branch;
        drive(1'b1, {1'b1, 6'b000011, 5'd2, 5'd3, 3'b000, 4'b0101, 1'b0, 7'b1100011}, 10'h010); tick;
        vectors++; if (ctrl_obs !== C_BR) begin miscompares++; $display("FAIL br_ctrl: got %b want %b", ctrl_obs, C_BR); end
        vectors++; if ({ex_imm, ex_rs1_data, ex_rs2_data} !== {12'h835, 8'hA5, 8'h11}) begin miscompares++; $display("FAIL br_fields: imm %h rs1d %h rs2d %h want 835 a5 11", ex_imm, ex_rs1_data, ex_rs2_data); end
    endtask

    task automatic test_load_use;
        drive(1'b1, enc_lw(5'd2, 5'd4), 10'h020); tick;
        vectors++; if ({ctrl_obs, ex_rd, ex_rs1_data} !== {C_LOAD, 5'd4, 8'h11}) begin miscompares++; $display("FAIL lw_issue: ctrl %b rd %0d rs1d %h want %b 4 11", ctrl_obs, ex_rd, ex_rs1_data, C_LOAD); end
        drive(1'b1, enc_r(7'h00, 5'd1, 5'd4, 5'd6), 10'h024); #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL lu_stall: got %b want 1", stall); end
        tick;
        vectors++; if ({ex_valid, ctrl_obs, ex_rd} !== '0) begin miscompares++; $display("FAIL lu_bubble: valid %b ctrl %b rd %0d want 0", ex_valid, ctrl_obs, ex_rd); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL lu_one_cycle: stall %b want 0", stall); end
        tick;
        vectors++; if ({ex_valid, ex_rd, ex_rs1, ex_pc} !== {1'b1, 5'd6, 5'd4, 10'h024}) begin miscompares++; $display("FAIL lu_reissue: valid %b rd %0d rs1 %0d pc %h want 1 6 4 024", ex_valid, ex_rd, ex_rs1, ex_pc); end
        vectors++; if (stall_cnt !== 4'd1) begin miscompares++; $display("FAIL lu_cnt: got %0d want 1", stall_cnt); end
        drive(1'b1, enc_lw(5'd2, 5'd4), 10'h028); tick;
        drive(1'b1, enc_sw(12'h008, 5'd4, 5'd2), 10'h02C); #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL sw_rs2_stall: got %b want 1", stall); end
        tick; tick;
        vectors++; if ({ctrl_obs, ex_imm, stall_cnt} !== {C_ST, 12'h008, 4'd2}) begin miscompares++; $display("FAIL sw_issue: ctrl %b imm %h stall_cnt %0d want %b 008 2", ctrl_obs, ex_imm, stall_cnt, C_ST); end
    endtask

    task automatic test_no_false_stall;
        drive(1'b1, enc_lw(5'd2, 5'd4), 10'h030); tick;
        drive(1'b1, enc_addi(12'h004, 5'd0, 5'd6), 10'h034); #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL unused_rs2_stall: got %b want 0", stall); end
        tick;
        vectors++; if ({ex_valid, ex_rd, ex_imm} !== {1'b1, 5'd6, 12'h004}) begin miscompares++; $display("FAIL unused_rs2_issue: valid %b rd %0d imm %h want 1 6 004", ex_valid, ex_rd, ex_imm); end
        drive(1'b1, enc_lw(5'd2, 5'd0), 10'h038); tick;
        drive(1'b1, enc_r(7'h00, 5'd0, 5'd0, 5'd6), 10'h03C); #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL x0_load_stall: got %b want 0", stall); end
        tick;
    endtask

    task automatic test_flush;
        drive(1'b1, enc_lw(5'd2, 5'd4), 10'h040); tick;
        drive(1'b1, enc_r(7'h00, 5'd1, 5'd4, 5'd6), 10'h044);
        flush = 1'b1; #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_kills_stall: got %b want 0", stall); end
        tick;
        vectors++; if ({ex_valid, ctrl_obs} !== '0) begin miscompares++; $display("FAIL flush_bubble: valid %b ctrl %b want 0", ex_valid, ctrl_obs); end
        vectors++; if ({flush_cnt, stall_cnt} !== {4'd1, 4'd2}) begin miscompares++; $display("FAIL flush_cnt: flush_cnt %0d stall_cnt %0d want 1 2", flush_cnt, stall_cnt); end
        flush = 1'b0; #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL after_flush_stall: got %b want 0", stall); end
        tick;
        vectors++; if ({ex_valid, ex_rd} !== {1'b1, 5'd6}) begin miscompares++; $display("FAIL after_flush_issue: valid %b rd %0d want 1 6", ex_valid, ex_rd); end
        drive(1'b0, 32'h0, '0);
        flush = 1'b1; tick; flush = 1'b0;
        vectors++; if ({ex_valid, flush_cnt} !== {1'b0, 4'd1}) begin miscompares++; $display("FAIL idle_flush: valid %b flush_cnt %0d want 0 1", ex_valid, flush_cnt); end
    endtask

    task automatic test_x0_illegal;
        wb(1'b1, 5'd0, 8'hFF); tick;
        wb(1'b0, '0, '0);
        drive(1'b1, enc_addi(12'h000, 5'd0, 5'd1), 10'h050); tick;
        vectors++; if (ex_rs1_data !== 8'h00) begin miscompares++; $display("FAIL x0_read: got %h want 00", ex_rs1_data); end
        wb(1'b1, 5'd0, 8'hEE);
        drive(1'b1, enc_r(7'h00, 5'd0, 5'd0, 5'd5), 10'h054); tick;
        wb(1'b0, '0, '0);
        vectors++; if ({ex_rs1_data, ex_rs2_data} !== 16'h0000) begin miscompares++; $display("FAIL x0_bypass: rs1d %h rs2d %h want 00 00", ex_rs1_data, ex_rs2_data); end
        drive(1'b1, 32'h0000_007F, 10'h058); tick;
        vectors++; if ({ex_valid, ex_illegal, ctrl_obs} !== {1'b1, 1'b1, C_NONE}) begin miscompares++; $display("FAIL illegal: valid %b illegal %b ctrl %b want 1 1 0", ex_valid, ex_illegal, ctrl_obs); end
        drive(1'b0, 32'h0000_007F, 10'h05C); tick;
        vectors++; if ({ex_valid, ex_illegal} !== 2'b00) begin miscompares++; $display("FAIL idle_bubble: valid %b illegal %b want 0 0", ex_valid, ex_illegal); end
    endtask

    task automatic test_back_to_back;
        logic [RW-1:0] e;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, enc_addi(12'(i), 5'd3, 5'(i + 10)), PC_SIZE'(10'h060 + 4 * i));
            exp_q.push_back(RW'(i + 10));
            tick;
            e = exp_q.pop_front();
            vectors++; if ({ex_valid, ex_rd, ex_imm} !== {1'b1, e, 12'(i)}) begin miscompares++; $display("FAIL b2b_%0d: valid %b rd %0d imm %h want 1 %0d %h", i, ex_valid, ex_rd, ex_imm, e, 12'(i)); end
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, enc_lw(5'd2, 5'd4), 10'h100); tick;
            drive(1'b1, enc_r(7'h00, 5'd1, 5'd4, 5'd6), 10'h104); tick; tick;
        end
        vectors++; if (stall_cnt !== 4'hF) begin miscompares++; $display("FAIL stall_sat: got %0d want 15", stall_cnt); end
        drive(1'b1, 32'h0, '0);
        flush = 1'b1;
        for (int i = 0; i < 16; i++) tick;
        flush = 1'b0;
        vectors++; if ({flush_cnt, stall_cnt} !== {4'hF, 4'hF}) begin miscompares++; $display("FAIL flush_sat: flush_cnt %0d stall_cnt %0d want 15 15", flush_cnt, stall_cnt); end
    endtask

    task automatic test_midstream_reset;
        drive(1'b1, enc_lw(5'd2, 5'd4), 10'h200); tick;
        drive(1'b1, enc_r(7'h00, 5'd1, 5'd4, 5'd6), 10'h204);
        flush = 1'b1; reset = 1'b1;
        wb(1'b1, 5'd9, 8'h77); tick;
        flush = 1'b0; reset = 1'b0;
        wb(1'b0, '0, '0);
        vectors++; if ({ex_valid, stall_cnt, flush_cnt, stall} !== '0) begin miscompares++; $display("FAIL mid_reset: valid %b stall_cnt %0d flush_cnt %0d stall %b want 0", ex_valid, stall_cnt, flush_cnt, stall); end
        drive(1'b1, enc_r(7'h00, 5'd9, 5'd3, 5'd5), 10'h208); tick;
        vectors++; if ({ex_rs1_data, ex_rs2_data} !== 16'h0000) begin miscompares++; $display("FAIL mid_reset_regs: rs1d %h rs2d %h want 00 00", ex_rs1_data, ex_rs2_data); end
    endtask

    initial begin
        test_reset;
        test_alu_bypass;
        test_branch;
        test_load_use;
        test_no_false_stall;
        test_flush;
        test_x0_illegal;
        test_back_to_back;
        test_saturation;
        test_midstream_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
